// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types and helpers for register-style slaves.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents: response encodings, slave FSM state types, and strb_merge, which
// applies a byte-enable mask to a register word.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic {
    W_COLLECT = 1'b0,
    W_RESP    = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // AXI4-Lite only allows 32- or 64-bit data, so the helper is sized for the
  // widest legal bus. Narrower callers zero-extend the inputs and keep the low
  // bits of the result.
  localparam int AXIL_MAX_DATA_BYTES = 8;
  localparam int AXIL_MAX_DATA_W     = AXIL_MAX_DATA_BYTES * 8;

  // Byte k of the result comes from new_dat when strb[k] is set, else from old_dat.
  function automatic logic [AXIL_MAX_DATA_W-1:0] strb_merge(
    input logic [AXIL_MAX_DATA_W-1:0]     old_dat,
    input logic [AXIL_MAX_DATA_W-1:0]     new_dat,
    input logic [AXIL_MAX_DATA_BYTES-1:0] strb
  );
    logic [AXIL_MAX_DATA_W-1:0] res;
    for (int k = 0; k < AXIL_MAX_DATA_BYTES; k++) begin
      res[k*8 +: 8] = strb[k] ? new_dat[k*8 +: 8] : old_dat[k*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi4_lite_reg_bank.sv
// AXI4-Lite slave backed by a bank of NUM_REGS read/write registers.
// Latency: write commits 1 cycle after both AW and W are held, with bvalid in the same cycle; read data is valid 1 cycle after AR.
// Backpressure: per-channel holding regs; readies drop while a beat is held or a response waits for bready/rready.
//
// Ports:
//   aclk, areset                  clock; synchronous active-high reset
//   s_aw*/s_w*/s_b*               write address, data and response channels
//   s_ar*/s_r*                    read address and data channels
//   reg_out                       all registers, flat; register i at [i*DW +: DW]
//   reg_wr_pulse                  one-cycle strobe, bit i, when register i is written
import axi4_lite_pkg::*;

module axi4_lite_reg_bank #(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_BYTES = 4,
  parameter int NUM_REGS   = 16
) (
  input  logic                              aclk,
  input  logic                              areset,
  // write address
  input  logic                              s_awvalid,
  output logic                              s_awready,
  input  logic [ADDR_BYTES*8-1:0]           s_awaddr,
  input  logic [2:0]                        s_awprot,
  // write data
  input  logic                              s_wvalid,
  output logic                              s_wready,
  input  logic [DATA_BYTES*8-1:0]           s_wdata,
  input  logic [DATA_BYTES-1:0]             s_wstrb,
  // write response
  output logic                              s_bvalid,
  input  logic                              s_bready,
  output logic [1:0]                        s_bresp,
  // read address
  input  logic                              s_arvalid,
  output logic                              s_arready,
  input  logic [ADDR_BYTES*8-1:0]           s_araddr,
  input  logic [2:0]                        s_arprot,
  // read data
  output logic                              s_rvalid,
  input  logic                              s_rready,
  output logic [DATA_BYTES*8-1:0]           s_rdata,
  output logic [1:0]                        s_rresp,
  // fabric side
  output logic [NUM_REGS*DATA_BYTES*8-1:0]  reg_out,
  output logic [NUM_REGS-1:0]               reg_wr_pulse
);

  localparam int DW    = DATA_BYTES * 8;
  localparam int AW    = ADDR_BYTES * 8;
  localparam int LSB   = $clog2(DATA_BYTES);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // Write holding buffer contents.
  typedef struct packed {
    logic [DW-1:0]         dat;
    logic [DATA_BYTES-1:0] strb;
  } wbuf_t;

  // Hit when no address bit above the index field is set and the index names
  // an existing register. Low byte-offset bits are don't-care.
  function automatic logic addr_hit(input logic [AW-1:0] a);
    logic [AW-1:0] upper;
    upper = a >> (LSB + IDX_W);
    return (upper == '0) && (int'(a[LSB +: IDX_W]) < NUM_REGS);
  endfunction

  logic [DW-1:0] regs [NUM_REGS];

  // ---------------------------------------------------------------------------
  // Write path state
  // ---------------------------------------------------------------------------
  wr_state_t                 w_state;
  logic                      aw_held;
  logic                      w_held;
  logic [AW-1:0]             aw_addr_q;
  wbuf_t                     w_buf_q;
  logic                      bvalid_q;
  axi_resp_t                 bresp_q;

  logic                      do_commit;
  logic                      w_hit;
  logic [IDX_W-1:0]          w_idx;
  logic [DW-1:0]             wr_old;
  logic [AXIL_MAX_DATA_W-1:0] merged_full;
  logic [DW-1:0]             wr_new;

  // Readies are a function of state only (plus reset), never of the valids.
  assign s_awready = !areset && (w_state == W_COLLECT) && !aw_held;
  assign s_wready  = !areset && (w_state == W_COLLECT) && !w_held;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;

  assign do_commit = (w_state == W_COLLECT) && aw_held && w_held;
  assign w_hit     = addr_hit(aw_addr_q);
  assign w_idx     = aw_addr_q[LSB +: IDX_W];

  always_comb begin
    wr_old = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_idx == IDX_W'(i)) wr_old = regs[i];
    end
    merged_full = strb_merge(AXIL_MAX_DATA_W'(wr_old),
                             AXIL_MAX_DATA_W'(w_buf_q.dat),
                             AXIL_MAX_DATA_BYTES'(w_buf_q.strb));
    wr_new = merged_full[DW-1:0];
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state      <= W_COLLECT;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_addr_q    <= '0;
      w_buf_q      <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= OKAY;
      reg_wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_wr_pulse[i] <= do_commit && w_hit && (w_idx == IDX_W'(i));
        if (do_commit && w_hit && (w_idx == IDX_W'(i))) regs[i] <= wr_new;
      end

      case (w_state)
        W_COLLECT: begin
          // Readies are low while held, so capture and commit never coincide.
          if (s_awvalid && s_awready) begin
            aw_held   <= 1'b1;
            aw_addr_q <= s_awaddr;
          end
          if (s_wvalid && s_wready) begin
            w_held       <= 1'b1;
            w_buf_q.dat  <= s_wdata;
            w_buf_q.strb <= s_wstrb;
          end
          if (do_commit) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= w_hit ? OKAY : SLVERR;
            w_state  <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_bready) begin
            bvalid_q <= 1'b0;
            w_state  <= W_COLLECT;
          end
        end
        default: w_state <= W_COLLECT;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  rd_state_t        r_state;
  logic             rvalid_q;
  logic [DW-1:0]    rdata_q;
  axi_resp_t        rresp_q;
  logic [IDX_W-1:0] ar_idx;
  logic [DW-1:0]    rd_val;

  assign s_arready = !areset && (r_state == R_IDLE);
  assign s_rvalid  = rvalid_q;
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;
  assign ar_idx    = s_araddr[LSB +: IDX_W];

  // Samples the array as it stands before the edge, so a read racing a commit
  // to the same register returns the old value.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) rd_val = regs[i];
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state  <= R_IDLE;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_arvalid && s_arready) begin
            rvalid_q <= 1'b1;
            if (addr_hit(s_araddr)) begin
              rdata_q <= rd_val;
              rresp_q <= OKAY;
            end else begin
              rdata_q <= '0;
              rresp_q <= SLVERR;
            end
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_rready) begin
            rvalid_q <= 1'b0;
            r_state  <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Fabric export
  // ---------------------------------------------------------------------------
  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_out[i*DW +: DW] = regs[i];
  end

  // Protection bits carry no meaning for a register bank; the wide merge
  // result is only partly consumed on a 32-bit bus.
  logic unused_ok;
  assign unused_ok = ^{s_awprot, s_arprot, merged_full};

endmodule

// File: tb/tb_axi4_lite_reg_bank.sv
// Directed bench for axi4_lite_reg_bank (16 x 32-bit registers).
// Inputs are driven and outputs sampled on the falling edge; handshakes land on the rising edge.
// Each task covers one scenario and carries its own inline comparisons.
module tb_axi4_lite_reg_bank;

  localparam int NR = 16;
  localparam int DW = 32;

  logic              aclk;
  logic              areset;
  logic              s_awvalid, s_awready;
  logic [31:0]       s_awaddr;
  logic [2:0]        s_awprot;
  logic              s_wvalid, s_wready;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic              s_bvalid, s_bready;
  logic [1:0]        s_bresp;
  logic              s_arvalid, s_arready;
  logic [31:0]       s_araddr;
  logic [2:0]        s_arprot;
  logic              s_rvalid, s_rready;
  logic [31:0]       s_rdata;
  logic [1:0]        s_rresp;
  logic [NR*DW-1:0]  reg_out;
  logic [NR-1:0]     reg_wr_pulse;

  int checks   = 0;
  int failures = 0;
  logic [NR-1:0] pulse_acc;

  axi4_lite_reg_bank #(.DATA_BYTES(4), .ADDR_BYTES(4), .NUM_REGS(NR)) dut (
    .aclk(aclk), .areset(areset),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Sticky record of any write pulse, sampled just after each rising edge.
  always @(posedge aclk) begin
    #1;
    pulse_acc = pulse_acc | reg_wr_pulse;
  end

  function automatic logic [31:0] rg(input int i);
    return reg_out[i*DW +: DW];
  endfunction

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    @(negedge aclk);
    s_awvalid = 1'b1; s_awaddr = a; s_wvalid = 1'b1; s_wdata = d; s_wstrb = s;
    n = 0;
    while (!(s_awready && s_wready) && n < 20) begin @(negedge aclk); n++; end
    @(negedge aclk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    n = 0;
    while (!s_bvalid && n < 20) begin @(negedge aclk); n++; end
    checks++;
    if (s_bvalid !== 1'b1) begin
      failures++;
      $display("FAIL wr_timeout addr=%h bvalid=%b required 1", a, s_bvalid);
    end
    resp = s_bresp;
    s_bready = 1'b1;
    @(negedge aclk);
    s_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(negedge aclk);
    s_arvalid = 1'b1; s_araddr = a;
    n = 0;
    while (!s_arready && n < 20) begin @(negedge aclk); n++; end
    @(negedge aclk);
    s_arvalid = 1'b0;
    n = 0;
    while (!s_rvalid && n < 20) begin @(negedge aclk); n++; end
    checks++;
    if (s_rvalid !== 1'b1) begin
      failures++;
      $display("FAIL rd_timeout addr=%h rvalid=%b required 1", a, s_rvalid);
    end
    d = s_rdata; resp = s_rresp;
    s_rready = 1'b1;
    @(negedge aclk);
    s_rready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge aclk);
    checks++;
    if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_outputs got aw/w/ar_rdy,b/r_vld=%b required 00000",
               {s_awready, s_wready, s_arready, s_bvalid, s_rvalid});
    end
    checks++;
    if (reg_wr_pulse !== 16'h0000) begin
      failures++;
      $display("FAIL reset_pulse got %h required 0000", reg_wr_pulse);
    end
    areset = 1'b0;
    @(negedge aclk);
    checks++;
    if ({s_awready, s_wready, s_arready} !== 3'b111) begin
      failures++;
      $display("FAIL reset_release_readies got %b required 111", {s_awready, s_wready, s_arready});
    end
    checks++;
    if (reg_out !== '0) begin
      failures++;
      $display("FAIL reset_regs got %h required 0", reg_out);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] d; logic [1:0] r;
    @(negedge aclk);
    s_awvalid = 1'b1; s_awaddr = 32'h08; s_wvalid = 1'b1; s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF;
    @(negedge aclk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    checks++;
    if ({s_bvalid, s_awready, s_wready} !== 3'b000) begin
      failures++;
      $display("FAIL wr1_held got bvalid,awrdy,wrdy=%b required 000", {s_bvalid, s_awready, s_wready});
    end
    @(negedge aclk);
    checks++;
    if (s_bvalid !== 1'b1 || s_bresp !== 2'b00) begin
      failures++;
      $display("FAIL wr1_resp got bvalid=%b bresp=%b required 1/00", s_bvalid, s_bresp);
    end
    checks++;
    if (reg_wr_pulse !== 16'h0004) begin
      failures++;
      $display("FAIL wr1_pulse got %h required 0004", reg_wr_pulse);
    end
    checks++;
    if (rg(2) !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL wr1_reg2 got %h required deadbeef", rg(2));
    end
    s_bready = 1'b1;
    @(negedge aclk);
    s_bready = 1'b0;
    checks++;
    if (reg_wr_pulse !== 16'h0000 || s_bvalid !== 1'b0) begin
      failures++;
      $display("FAIL wr1_pulse_end got pulse=%h bvalid=%b required 0000/0", reg_wr_pulse, s_bvalid);
    end
    axi_read(32'h08, d, r);
    checks++;
    if (d !== 32'hDEADBEEF || r !== 2'b00) begin
      failures++;
      $display("FAIL rd1 got %h/%b required deadbeef/00", d, r);
    end
  endtask

  task automatic test_strobe_order();
    @(negedge aclk);
    s_wvalid = 1'b1; s_wdata = 32'h11223344; s_wstrb = 4'b0101;
    @(negedge aclk);
    s_wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({s_awready, s_wready} !== 2'b10) begin
        failures++;
        $display("FAIL wfirst_readies cyc=%0d got awrdy,wrdy=%b required 10", k, {s_awready, s_wready});
      end
      if (k == 2) begin s_awvalid = 1'b1; s_awaddr = 32'h08; end
      @(negedge aclk);
    end
    s_awvalid = 1'b0;
    @(negedge aclk);
    checks++;
    if (s_bvalid !== 1'b1 || s_bresp !== 2'b00 || rg(2) !== 32'hDE22BE44) begin
      failures++;
      $display("FAIL wfirst_merge got bvalid=%b bresp=%b reg2=%h required 1/00/de22be44",
               s_bvalid, s_bresp, rg(2));
    end
    s_bready = 1'b1;
    @(negedge aclk);
    s_bready = 1'b0;
  endtask

  task automatic test_decode_miss();
    logic [31:0] d; logic [1:0] r;
    logic [NR*DW-1:0] exp_regs;
    exp_regs = '0;
    exp_regs[2*DW +: DW] = 32'hDE22BE44;
    pulse_acc = '0;
    axi_write(32'h40, 32'hCAFEF00D, 4'hF, r);
    checks++;
    if (r !== 2'b10) begin
      failures++;
      $display("FAIL miss_bresp got %b required 10", r);
    end
    axi_read(32'h1000, d, r);
    checks++;
    if (r !== 2'b10 || d !== 32'h0) begin
      failures++;
      $display("FAIL miss_read got %h/%b required 00000000/10", d, r);
    end
    checks++;
    if (pulse_acc !== 16'h0000) begin
      failures++;
      $display("FAIL miss_pulse got %h required 0000", pulse_acc);
    end
    checks++;
    if (reg_out !== exp_regs) begin
      failures++;
      $display("FAIL miss_regs got %h required %h", reg_out, exp_regs);
    end
  endtask

  task automatic test_backpressure();
    logic [42:0] got;
    @(negedge aclk);
    s_awvalid = 1'b1; s_awaddr = 32'h0C; s_wvalid = 1'b1; s_wdata = 32'h1; s_wstrb = 4'hF;
    s_arvalid = 1'b1; s_araddr = 32'h08;
    @(negedge aclk);
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      got = {s_bvalid, s_bresp, s_rvalid, s_rresp, s_rdata, s_awready, s_wready, s_arready};
      checks++;
      if (got !== {1'b1, 2'b00, 1'b1, 2'b00, 32'hDE22BE44, 3'b000}) begin
        failures++;
        $display("FAIL stall cyc=%0d got %h required %h", k, got,
                 {1'b1, 2'b00, 1'b1, 2'b00, 32'hDE22BE44, 3'b000});
      end
    end
    s_bready = 1'b1; s_rready = 1'b1;
    @(negedge aclk);
    s_bready = 1'b0; s_rready = 1'b0;
    checks++;
    if ({s_bvalid, s_rvalid, s_awready, s_wready, s_arready} !== 5'b00111) begin
      failures++;
      $display("FAIL stall_release got %b required 00111",
               {s_bvalid, s_rvalid, s_awready, s_wready, s_arready});
    end
  endtask

  task automatic test_read_during_commit();
    logic [31:0] d; logic [1:0] r;
    @(negedge aclk);
    s_awvalid = 1'b1; s_awaddr = 32'h0C; s_wvalid = 1'b1; s_wdata = 32'h5; s_wstrb = 4'hF;
    @(negedge aclk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    s_arvalid = 1'b1; s_araddr = 32'h0C;
    @(negedge aclk);
    s_arvalid = 1'b0;
    checks++;
    if (s_rvalid !== 1'b1 || s_rdata !== 32'h1) begin
      failures++;
      $display("FAIL race_old got rvalid=%b rdata=%h required 1/00000001", s_rvalid, s_rdata);
    end
    checks++;
    if (s_bvalid !== 1'b1 || rg(3) !== 32'h5) begin
      failures++;
      $display("FAIL race_commit got bvalid=%b reg3=%h required 1/00000005", s_bvalid, rg(3));
    end
    s_bready = 1'b1; s_rready = 1'b1;
    @(negedge aclk);
    s_bready = 1'b0; s_rready = 1'b0;
    axi_read(32'h0C, d, r);
    checks++;
    if (d !== 32'h5 || r !== 2'b00) begin
      failures++;
      $display("FAIL race_new got %h/%b required 00000005/00", d, r);
    end
  endtask

  task automatic test_reset_midflight();
    logic [1:0] r;
    @(negedge aclk);
    s_awvalid = 1'b1; s_awaddr = 32'h00; s_wvalid = 1'b1; s_wdata = 32'h77; s_wstrb = 4'hF;
    @(negedge aclk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    @(negedge aclk);
    checks++;
    if (s_bvalid !== 1'b1 || rg(0) !== 32'h77) begin
      failures++;
      $display("FAIL mid_pre got bvalid=%b reg0=%h required 1/00000077", s_bvalid, rg(0));
    end
    areset = 1'b1;
    @(negedge aclk);
    checks++;
    if ({s_bvalid, s_rvalid, s_awready, s_wready, s_arready} !== 5'b00000 || reg_wr_pulse !== 16'h0) begin
      failures++;
      $display("FAIL mid_reset got vld/rdy=%b pulse=%h required 00000/0000",
               {s_bvalid, s_rvalid, s_awready, s_wready, s_arready}, reg_wr_pulse);
    end
    checks++;
    if (reg_out !== '0) begin
      failures++;
      $display("FAIL mid_regs got %h required 0", reg_out);
    end
    areset = 1'b0;
    @(negedge aclk);
    checks++;
    if ({s_awready, s_wready, s_arready} !== 3'b111) begin
      failures++;
      $display("FAIL mid_release got %b required 111", {s_awready, s_wready, s_arready});
    end
    axi_write(32'h04, 32'hA5A5A5A5, 4'b0011, r);
    checks++;
    if (r !== 2'b00 || rg(1) !== 32'h0000A5A5) begin
      failures++;
      $display("FAIL mid_after got %b/%h required 00/0000a5a5", r, rg(1));
    end
  endtask

  initial begin
    areset = 1'b1;
    s_awvalid = 1'b0; s_awaddr = '0; s_awprot = '0;
    s_wvalid = 1'b0; s_wdata = '0; s_wstrb = '0;
    s_bready = 1'b0;
    s_arvalid = 1'b0; s_araddr = '0; s_arprot = '0;
    s_rready = 1'b0;
    pulse_acc = '0;

    test_reset();
    test_write_read();
    test_strobe_order();
    test_decode_miss();
    test_backpressure();
    test_read_during_commit();
    test_reset_midflight();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
